cache_refill_ctrl: RTL and testbench
====================================

# cache_refill_ctrl

Blocking controller for the data-side direct-mapped cache. It owns the tag, valid and data arrays (one 32-bit word per line) and answers CPU loads and stores. On a load miss it issues a single-word refill read to main data memory over a req/ack handshake, stalls the CPU until the word returns, and installs the line. Every store is written through to memory.

## Interface
Parameters:
- `SETS`, default 8: number of lines (power of two); index = `addr[log2(SETS)+1:2]`.
- `TAG_W`, default 27: tag width = `30 - log2(SETS)`, i.e. `addr[31:5]` at default.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cpu_req` in 1: CPU access valid; held stable with addr/we/wdata while `cpu_stall`=1.
- `cpu_we` in 1: 1 = store, 0 = load.
- `cpu_addr` in 32: byte address; `[1:0]` ignored.
- `cpu_wdata` in 32: store data.
- `cpu_rdata` out 32: load data.
- `cpu_stall` out 1: access not yet complete.
- `mem_req` out 1: memory request valid.
- `mem_we` out 1: memory write (store) vs read (refill).
- `mem_addr` out 32: word-aligned (`[1:0]`=0) memory address.
- `mem_wdata` out 32: memory write data.
- `mem_ack` in 1: memory completes the current request this cycle; `mem_rdata` valid when `mem_we`=0.
- `mem_rdata` in 32: refill data.

## Operation
- States: IDLE, RD_MISS, WR_THRU, DONE.
- IDLE, `cpu_req`=0: no action, `cpu_stall`=0.
- IDLE, load hit (valid & tag match): `cpu_rdata` = line data combinationally, `cpu_stall`=0, stay IDLE.
- IDLE, load miss: `cpu_stall`=1; -> RD_MISS; latch word address.
- IDLE, store (hit or miss): `cpu_stall`=1; -> WR_THRU; latch address and data.
- RD_MISS: `mem_req`=1, `mem_we`=0; on `mem_ack`: capture `mem_rdata`, write data/tag, set valid -> DONE.
- WR_THRU: `mem_req`=1, `mem_we`=1, `mem_wdata` = latched data; on `mem_ack`: if hit, update line data -> DONE. On a store miss, the line is untouched (no-allocate) unless the macro below is enabled.
- DONE: `cpu_stall`=0; `cpu_rdata` = captured refill word (loads); -> IDLE unconditionally. A new request is accepted only in IDLE.
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are registered and stable from request until ack.
- `mem_ack` outside RD_MISS/WR_THRU is ignored.

## Timing
- Reset: state IDLE, all valid bits 0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_rdata`=0, `cpu_stall`=0. Tag and data arrays are not reset.
- Load hit: 0 extra cycles, data in the request cycle.
- Load miss: `mem_req` rises at cycle 1. With ack at cycle 1+N, DONE (stall low, data valid) is at cycle 2+N. Total latency is 2+N cycles (minimum 2 with same-cycle ack).
- Store: same 2+N latency.
- Reset asserted mid-transaction: `mem_req` and `cpu_stall` drop immediately (async). The in-flight refill is discarded and no line is written.
- Load to the same index after a refill hits on the first IDLE cycle after DONE.

## Configuration
- `CACHE_WRITE_ALLOCATE_EN` defined: on store-miss ack, the line's tag and data are written and valid is set, so a subsequent load to that address hits.
- Undefined: store miss leaves the line unchanged (write-no-allocate); a subsequent load to that address misses.

## Test plan
- Reset, load 0x0000_0040 with memory returning 0xDEADBEEF after 3 waits -> `mem_req` held for cycles 1–4 with `mem_addr`=0x40; DONE at cycle 5 with `cpu_rdata`=0xDEADBEEF; an immediate reload hits with stall=0.
- Load 0x40 then 0x140 (same index 0, different tag) -> second load misses and evicts; a reload of 0x40 misses again.
- Store 0x40=0x12345678 after 0x40 is cached, ack same cycle -> `mem_we`=1, `mem_wdata`=0x12345678; 2-cycle stall; the next load of 0x40 hits and returns 0x12345678.
- Store miss to 0x80, then load 0x80 -> macro off: the load misses and refills; macro on: the load hits.
- Assert `rst` during RD_MISS wait -> `mem_req`=0 immediately; after release, load the same address -> misses (valid was cleared).
- Spurious `mem_ack` in IDLE, plus addr[1:0]=2'b11 on a load -> no state change; `mem_addr[1:0]`=0.

Source files
------------

// File: rtl/cache_refill_ctrl.sv
// rtl/cache_refill_ctrl.sv - blocking direct-mapped data cache controller with single-word refill and write-through
//
// Optional feature macro: CACHE_WRITE_ALLOCATE_EN (store misses allocate the line).
//
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   cpu_req/cpu_we           CPU access valid / store (1) vs load (0)
//   cpu_addr/cpu_wdata       byte address and store data
//   cpu_rdata/cpu_stall      load data / access not yet complete
//   mem_req/mem_we           registered memory request / write vs refill read
//   mem_addr/mem_wdata       registered word-aligned address and write data
//   mem_ack/mem_rdata        memory completion strobe and refill data

module cache_refill_ctrl #(
    parameter int SETS  = 8,
    parameter int TAG_W = 30 - $clog2(SETS)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int IDX_W = $clog2(SETS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_THRU = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t state, next_state;

    logic [TAG_W-1:0] tag_arr  [SETS];
    logic [31:0]      data_arr [SETS];
    logic [SETS-1:0]  valid;

    logic [31:0] rdata_q;

    logic [IDX_W-1:0] cpu_idx;
    logic [TAG_W-1:0] cpu_tag;
    logic [IDX_W-1:0] lat_idx;
    logic [TAG_W-1:0] lat_tag;
    logic             cpu_hit;
    logic             lat_hit;

    logic accept;
    logic refill_done;
    logic store_done;
    logic store_install;

    // The latched request lives in mem_addr, which stays put until the next
    // accepted miss or store, so it doubles as the line pointer for the ack.
    assign cpu_idx = cpu_addr[IDX_W+1:2];
    assign cpu_tag = cpu_addr[31:IDX_W+2];
    assign lat_idx = mem_addr[IDX_W+1:2];
    assign lat_tag = mem_addr[31:IDX_W+2];

    assign cpu_hit = valid[cpu_idx] && (tag_arr[cpu_idx] == cpu_tag);
    assign lat_hit = valid[lat_idx] && (tag_arr[lat_idx] == lat_tag);

`ifdef CACHE_WRITE_ALLOCATE_EN
    assign store_install = 1'b1;
`else
    assign store_install = lat_hit;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        cpu_stall   = 1'b0;
        cpu_rdata   = rdata_q;
        accept      = 1'b0;
        refill_done = 1'b0;
        store_done  = 1'b0;
        case (state)
            IDLE: begin
                // rst gating keeps stall low while reset is held with a request pending.
                if (cpu_req && !rst) begin
                    if (cpu_we) begin
                        cpu_stall  = 1'b1;
                        accept     = 1'b1;
                        next_state = WR_THRU;
                    end else if (!cpu_hit) begin
                        cpu_stall  = 1'b1;
                        accept     = 1'b1;
                        next_state = RD_MISS;
                    end else begin
                        cpu_rdata = data_arr[cpu_idx];
                    end
                end
            end
            RD_MISS: begin
                cpu_stall = 1'b1;
                if (mem_ack) begin
                    refill_done = 1'b1;
                    next_state  = DONE;
                end
            end
            WR_THRU: begin
                cpu_stall = 1'b1;
                if (mem_ack) begin
                    store_done = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            rdata_q   <= 32'd0;
            valid     <= '0;
        end else begin
            if (accept) begin
                mem_req  <= 1'b1;
                mem_we   <= cpu_we;
                mem_addr <= cpu_addr & 32'hFFFF_FFFC;
                if (cpu_we) begin
                    mem_wdata <= cpu_wdata;
                end
            end
            if (refill_done) begin
                mem_req          <= 1'b0;
                rdata_q          <= mem_rdata;
                valid[lat_idx]   <= 1'b1;
            end
            if (store_done) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
                if (store_install) begin
                    valid[lat_idx] <= 1'b1;
                end
            end
        end
    end

    // Tag and data arrays carry no reset; writes only happen on an ack in
    // RD_MISS/WR_THRU, and reset forces IDLE, so an aborted refill never lands.
    always_ff @(posedge clk) begin
        if (refill_done) begin
            tag_arr[lat_idx]  <= lat_tag;
            data_arr[lat_idx] <= mem_rdata;
        end else if (store_done && store_install) begin
            tag_arr[lat_idx]  <= lat_tag;
            data_arr[lat_idx] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb/tb_cache_refill_ctrl.sv - scoreboard testbench for cache_refill_ctrl

module tb_cache_refill_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = 32'd0;
    logic [31:0] cpu_wdata = 32'd0;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    cache_refill_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        is_load;
        logic [31:0] rdata;
        string       name;
    } exp_t;

    exp_t sb[$];

    logic [31:0] mem_model [logic [31:0]];
    int          ack_wait = 0;
    logic        spurious = 1'b0;
    int          reads = 0;
    int          req_cycles = 0;
    int          last_req_cycles = 0;
    logic [31:0] ack_addr = 32'd0;
    logic        ack_we = 1'b0;
    logic [31:0] ack_wdata = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory responder: acks after ack_wait extra cycles of mem_req.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        forever begin
            @(negedge clk);
            if (mem_req && !rst) begin
                req_cycles++;
                if (wait_cnt == ack_wait) begin
                    mem_ack         = 1'b1;
                    ack_addr        = mem_addr;
                    ack_we          = mem_we;
                    ack_wdata       = mem_wdata;
                    last_req_cycles = req_cycles;
                    if (mem_we) begin
                        mem_model[mem_addr] = mem_wdata;
                    end else begin
                        mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0;
                        reads++;
                    end
                    wait_cnt   = 0;
                    req_cycles = 0;
                end else begin
                    mem_ack = 1'b0;
                    wait_cnt++;
                end
            end else begin
                mem_ack    = spurious;
                wait_cnt   = 0;
                req_cycles = 0;
            end
        end
    end

    // Monitor: a completed access is one presented with stall low.
    always @(negedge clk) begin
        if (!rst && cpu_req && !cpu_stall) begin
            if (sb.size() == 0) begin
                chk("unexpected_completion", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.is_load) begin
                    chk({e.name, "_rdata"}, cpu_rdata, e.rdata);
                end
            end
        end
    end

    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input int exp_stall, input string name);
        exp_t e;
        int   n;
        bit   done;
        e.is_load = !we;
        e.rdata   = exp_rdata;
        e.name    = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        n    = 0;
        done = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            if (!cpu_stall) done = 1;
            else n++;
        end
        if (!done) begin
            chk({name, "_timeout"}, 32'd1, 32'd0);
        end
        chk({name, "_stall_cycles"}, n, exp_stall);
    endtask

    task automatic go_idle(input int n);
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    initial begin
        int r0;
        mem_model[32'h40]  = 32'hDEADBEEF;
        mem_model[32'h140] = 32'hCAFEF00D;
        mem_model[32'h44]  = 32'h0BADC0DE;
        mem_model[32'h48]  = 32'h5555AAAA;
        mem_model[32'h80]  = 32'h11111111;

        repeat (2) @(negedge clk);
        chk("rst_cpu_stall", {31'd0, cpu_stall}, 32'd0);
        chk("rst_mem_req",   {31'd0, mem_req},   32'd0);
        chk("rst_mem_we",    {31'd0, mem_we},    32'd0);
        chk("rst_mem_addr",  mem_addr,  32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        rst = 1'b0;

        // Miss with 3 wait states, then an immediate hit.
        ack_wait = 3;
        r0 = reads;
        access(1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 5, "ld40_miss");
        chk("ld40_req_cycles", last_req_cycles, 32'd4);
        chk("ld40_mem_addr", ack_addr, 32'h40);
        access(1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 0, "ld40_hit");
        chk("ld40_reads", reads - r0, 32'd1);

        // Conflict eviction on index 0.
        ack_wait = 0;
        access(1'b0, 32'h140, 32'h0, 32'hCAFEF00D, 2, "ld140_evict");
        r0 = reads;
        access(1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 2, "ld40_remiss");
        chk("ld40_remiss_reads", reads - r0, 32'd1);

        // Store hit, then a load hit returning the new word.
        access(1'b1, 32'h40, 32'h12345678, 32'h0, 2, "st40_hit");
        chk("st40_mem_we", {31'd0, ack_we}, 32'd1);
        chk("st40_mem_wdata", ack_wdata, 32'h12345678);
        r0 = reads;
        access(1'b0, 32'h40, 32'h0, 32'h12345678, 0, "ld40_after_st");
        chk("ld40_after_st_reads", reads - r0, 32'd0);

        // Store miss to 0x80, then load it.
        access(1'b1, 32'h80, 32'hA5A5A5A5, 32'h0, 2, "st80_miss");
        r0 = reads;
`ifdef CACHE_WRITE_ALLOCATE_EN
        access(1'b0, 32'h80, 32'h0, 32'hA5A5A5A5, 0, "ld80_alloc_hit");
        chk("ld80_reads", reads - r0, 32'd0);
`else
        access(1'b0, 32'h80, 32'h0, 32'hA5A5A5A5, 2, "ld80_noalloc_miss");
        chk("ld80_reads", reads - r0, 32'd1);
`endif

        // Reset during a refill wait.
        access(1'b0, 32'h40, 32'h0, 32'h12345678, 2, "ld40_pre_rst");
        ack_wait = 10;
        @(posedge clk);
        #1;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h44;
        repeat (3) @(negedge clk);
        chk("abort_mem_req_before", {31'd0, mem_req}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_mem_req", {31'd0, mem_req}, 32'd0);
        chk("abort_cpu_stall", {31'd0, cpu_stall}, 32'd0);
        cpu_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ack_wait = 0;
        access(1'b0, 32'h44, 32'h0, 32'h0BADC0DE, 2, "ld44_after_rst");
        access(1'b0, 32'h40, 32'h0, 32'h12345678, 2, "ld40_after_rst");

        // Spurious ack in IDLE and ignored byte offset.
        go_idle(0);
        spurious = 1'b1;
        repeat (2) @(negedge clk);
        spurious = 1'b0;
        chk("spur_cpu_stall", {31'd0, cpu_stall}, 32'd0);
        chk("spur_mem_req", {31'd0, mem_req}, 32'd0);
        r0 = reads;
        access(1'b0, 32'h43, 32'h0, 32'h12345678, 0, "ld43_hit");
        access(1'b0, 32'h4B, 32'h0, 32'h5555AAAA, 2, "ld4b_miss");
        chk("ld4b_mem_addr", ack_addr, 32'h48);
        chk("spur_reads", reads - r0, 32'd1);

        go_idle(3);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
